// File: rtl/lift_pkg.sv
// lift_pkg: shared lift constants, motor encodings and hall-call panel FSM states
package lift_pkg;
   localparam int NUM_FLOORS_DEF = 11;
   localparam int FLOOR_W = 4;
   localparam logic [FLOOR_W-1:0] FLOOR_NONE = 4'hF;
   localparam logic [1:0] MOTOR_IDLE = 2'b00;
   localparam logic [1:0] MOTOR_UP = 2'b11;
   localparam logic [1:0] MOTOR_DOWN = 2'b10;
   typedef enum logic [1:0] {IDLE, ISSUE, GAP} hcp_state_t;
   function automatic int wrap_add(int a, int b, int n);
      return (a + b >= n) ? a + b - n : a + b;
   endfunction
endpackage

// File: rtl/hall_btn_debounce.sv
// hall_btn_debounce: synchronise a raw button, debounce it and pulse press on each accepted rising level
module hall_btn_debounce #(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);
   localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);
   logic s1, s2, lvl, done;
   logic [CW-1:0] cnt;
   assign done = (s2 != lvl) && (cnt == LAST);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         lvl <= 1'b0;
         cnt <= '0;
         press <= 1'b0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
         cnt <= (s2 == lvl || done) ? '0 : cnt + 1'b1;
         lvl <= done ? s2 : lvl;
         press <= done & s2;
      end
   end
endmodule

// File: rtl/hall_call_panel.sv
// hall_call_panel: latch debounced hall calls, light lamps and serialise calls onto the floor-request bus
module hall_call_panel
   import lift_pkg::*;
#(
   parameter int NUM_FLOORS = NUM_FLOORS_DEF,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] btn,
   input  logic [FLOOR_W-1:0]    lift_floor,
   input  logic [1:0]            motor_signal,
   input  logic                  req_ready,
   output logic                  req_valid,
   output logic [FLOOR_W-1:0]    req_floor,
   output logic [NUM_FLOORS-1:0] call_lamp,
   output logic [FLOOR_W-1:0]    pending_cnt
);
   logic [NUM_FLOORS-1:0] press, svc, new_call, elig, sent, lamp_n, sent_n;
   logic [FLOOR_W-1:0] g, g_n, rr_ptr, rr_n, pick;
   logic found;
   hcp_state_t state, state_n;
   for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
      hall_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
         .clk(clk),
         .rst(rst),
         .btn_raw(btn[f]),
         .press(press[f])
      );
      assign svc[f] = (lift_floor == FLOOR_W'(f)) && (motor_signal == MOTOR_IDLE);
   end
   // fresh presses join arbitration in the same cycle so IDLE grants one cycle after press
   assign new_call = press & ~call_lamp & ~svc;
   assign elig = ((call_lamp & ~sent) | new_call) & ~svc;
   always_comb begin
      found = 1'b0;
      pick = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (!found && elig[FLOOR_W'(wrap_add(int'(rr_ptr), i, NUM_FLOORS))]) begin
            found = 1'b1;
            pick = FLOOR_W'(wrap_add(int'(rr_ptr), i, NUM_FLOORS));
         end
      end
   end
   always_comb begin
      state_n = state;
      g_n = g;
      rr_n = rr_ptr;
      lamp_n = (call_lamp | new_call) & ~svc;
      sent_n = sent & ~new_call & ~svc;
      unique case (state)
         IDLE: begin
            state_n = found ? ISSUE : IDLE;
            g_n = found ? pick : g;
            rr_n = found ? FLOOR_W'(wrap_add(int'(pick), 1, NUM_FLOORS)) : rr_ptr;
         end
         ISSUE: begin
            state_n = svc[g] ? IDLE : req_ready ? GAP : ISSUE;
            if (!svc[g] && req_ready) sent_n[g] = 1'b1;
         end
         GAP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         g <= '0;
         rr_ptr <= '0;
         call_lamp <= '0;
         sent <= '0;
         req_valid <= 1'b0;
         req_floor <= FLOOR_NONE;
         pending_cnt <= '0;
      end else begin
         state <= state_n;
         g <= g_n;
         rr_ptr <= rr_n;
         call_lamp <= lamp_n;
         sent <= sent_n;
         req_valid <= state_n == ISSUE;
         req_floor <= (state_n == ISSUE) ? g_n : FLOOR_NONE;
         pending_cnt <= FLOOR_W'($countones(call_lamp));
      end
   end
endmodule

// File: tb/tb_hall_call_panel.sv
// tb_hall_call_panel: directed checks of debounce, arbitration, handshake, service and async reset
module tb_hall_call_panel;
   logic clk = 1'b0;
   logic rst;
   logic [10:0] btn;
   logic [3:0] lift_floor;
   logic [1:0] motor_signal;
   logic req_ready, req_valid;
   logic [3:0] req_floor, pending_cnt;
   logic [10:0] call_lamp;
   int checks = 0;
   int errors = 0;
   logic [3:0] issued[$];
   logic ok;
   always #5 clk = ~clk;
   hall_call_panel #(.NUM_FLOORS(11), .DEBOUNCE_CYC(4)) dut (
      .clk(clk),
      .rst(rst),
      .btn(btn),
      .lift_floor(lift_floor),
      .motor_signal(motor_signal),
      .req_ready(req_ready),
      .req_valid(req_valid),
      .req_floor(req_floor),
      .call_lamp(call_lamp),
      .pending_cnt(pending_cnt)
   );
   always @(negedge clk) if (!rst && req_valid && req_ready) issued.push_back(req_floor);
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic press_btn(input int f, input int hold);
      btn[f] = 1'b1;
      tick(hold);
      btn[f] = 1'b0;
      tick(10);
   endtask
   task automatic wait_valid(input int max);
      int n = 0;
      while (!req_valid && n < max) begin
         tick(1);
         n++;
      end
      check("wait_valid", 32'(req_valid), 1);
   endtask
   initial begin
      rst = 1'b1;
      btn = '0;
      lift_floor = 4'hF;
      motor_signal = 2'b00;
      req_ready = 1'b1;
      tick(2);
      check("rst_valid", 32'(req_valid), 0);
      check("rst_floor", 32'(req_floor), 32'hF);
      check("rst_lamp", 32'(call_lamp), 0);
      check("rst_pending", 32'(pending_cnt), 0);
      rst = 1'b0;
      tick(1);
      btn[5] = 1'b1;
      tick(6);
      check("t1_latency", 32'(req_valid), 0);
      tick(1);
      check("t1_valid", 32'(req_valid), 1);
      check("t1_floor", 32'(req_floor), 5);
      check("t1_lamp", 32'(call_lamp), 32'h20);
      tick(1);
      check("t1_gap_valid", 32'(req_valid), 0);
      check("t1_gap_floor", 32'(req_floor), 32'hF);
      check("t1_pending", 32'(pending_cnt), 1);
      tick(2);
      btn[5] = 1'b0;
      tick(10);
      check("t1_issues", 32'(issued.size()), 1);
      check("t1_issue0", 32'(issued[0]), 5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      issued.delete();
      btn[2] = 1'b1;
      btn[7] = 1'b1;
      tick(7);
      check("t2_first", 32'(req_floor), 2);
      tick(1);
      check("t2_gap", 32'(req_floor), 32'hF);
      tick(2);
      check("t2_second", 32'(req_floor), 7);
      btn = '0;
      tick(12);
      check("t2_issues", 32'(issued.size()), 2);
      check("t2_issue0", 32'(issued[0]), 2);
      check("t2_issue1", 32'(issued[1]), 7);
      check("t2_lamp", 32'(call_lamp), 32'h84);
      check("t2_pending", 32'(pending_cnt), 2);
      btn[3] = 1'b1;
      tick(2);
      btn[3] = 1'b0;
      tick(12);
      check("t3_glitch_lamp", 32'(call_lamp), 32'h84);
      check("t3_glitch_issue", 32'(issued.size()), 2);
      press_btn(4, 8);
      check("t3_issue4", 32'(issued.size()), 3);
      check("t3_last", 32'(issued[2]), 4);
      press_btn(4, 8);
      check("t3_no_dup", 32'(issued.size()), 3);
      check("t3_lamp", 32'(call_lamp), 32'h94);
      check("t3_pending", 32'(pending_cnt), 3);
      req_ready = 1'b0;
      btn[9] = 1'b1;
      wait_valid(20);
      check("t4_floor", 32'(req_floor), 9);
      btn[9] = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (!(req_valid === 1'b1 && req_floor === 4'd9)) ok = 1'b0;
      end
      check("t4_hold", 32'(ok), 1);
      lift_floor = 4'd9;
      tick(1);
      check("t4_withdraw_valid", 32'(req_valid), 0);
      check("t4_withdraw_floor", 32'(req_floor), 32'hF);
      check("t4_lamp", 32'(call_lamp), 32'h94);
      lift_floor = 4'hF;
      req_ready = 1'b1;
      tick(3);
      check("t4_issues", 32'(issued.size()), 3);
      press_btn(6, 8);
      check("t5_issue6", 32'(issued.size()), 4);
      check("t5_lamp_on", 32'(call_lamp), 32'hD4);
      motor_signal = 2'b11;
      lift_floor = 4'd6;
      tick(3);
      check("t5_moving", 32'(call_lamp), 32'hD4);
      motor_signal = 2'b00;
      tick(1);
      check("t5_stopped", 32'(call_lamp), 32'h94);
      press_btn(6, 8);
      check("t5_suppress_lamp", 32'(call_lamp), 32'h94);
      check("t5_suppress_issue", 32'(issued.size()), 4);
      check("t5_pending", 32'(pending_cnt), 3);
      lift_floor = 4'hF;
      req_ready = 1'b0;
      btn[0] = 1'b1;
      wait_valid(20);
      check("t6_floor", 32'(req_floor), 0);
      btn[0] = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("t6_async_valid", 32'(req_valid), 0);
      check("t6_async_floor", 32'(req_floor), 32'hF);
      check("t6_async_lamp", 32'(call_lamp), 0);
      check("t6_async_pending", 32'(pending_cnt), 0);
      tick(1);
      rst = 1'b0;
      tick(2);
      check("t6_after", 32'(req_valid), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
